// File: rtl/uart_rx_param_if.sv
// Receive-side bundle between the serial line / baud tick source and uart_rx_param.
// The master drives the line and the oversampling tick; the slave (receiver) returns frames.
interface uart_rx_param_if #(
  parameter int unsigned DBIT = 8
);
  logic            rx;
  logic            s_tick;
  logic            rx_done_tick;
  logic [DBIT-1:0] dout;
  logic            framing_err;
  logic            parity_err;

  modport master (
    output rx, s_tick,
    input  rx_done_tick, dout, framing_err, parity_err
  );

  modport slave (
    input  rx, s_tick,
    output rx_done_tick, dout, framing_err, parity_err
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with input synchroniser, false-start rejection and
// framing check; define UART_RX_PARITY_EN to compile in the parity bit stage and parity_err flag.
module uart_rx_param #(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned OVS        = 16,
  parameter int unsigned SB_TICK    = 16,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_param_if.slave bus
);

  localparam int unsigned SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int unsigned SW   = $clog2(SMAX);
  localparam int unsigned NW   = $clog2(DBIT);

  localparam logic [SW-1:0] TICK_MID  = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] TICK_BIT  = SW'(OVS - 1);
  localparam logic [SW-1:0] TICK_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
  localparam logic [2:0] S_AFTER_DATA = S_STOP;
  // Odd/even selection has no effect without the parity stage.
  localparam bit PERR_TIE = PARITY_ODD & 1'b0;
`endif

  logic            rx_meta_q, rx_s_q;
  logic [2:0]      state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            armed_q, armed_d;
  logic            done_q, done_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic            p_q, p_d;
  logic            perr_q, perr_d;
`endif

  logic tick;
  assign tick = bus.s_tick;

  // Two-flop synchroniser; idle-high reset value avoids a spurious start after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      armed_q <= 1'b1;
      done_q  <= 1'b0;
      dout_q  <= '0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      p_q     <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      armed_q <= armed_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      p_q     <= p_d;
      perr_q  <= perr_d;
`endif
    end
  end

  // Frame sequencing; results are loaded on the final stop tick so they are visible during FINISH.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    armed_d = armed_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    p_d     = p_q;
    perr_d  = perr_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        s_d = '0;
        // After a break the line must be seen high before a new start is accepted.
        if (rx_s_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (tick) begin
          if (s_q == TICK_MID) begin
            s_d = '0;
            if (rx_s_q) begin
              state_d = S_IDLE;
            end else begin
              n_d     = '0;
              state_d = S_DATA;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      S_DATA: begin
        if (tick) begin
          if (s_q == TICK_BIT) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
              state_d = S_AFTER_DATA;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (s_q == TICK_BIT) begin
            s_d     = '0;
            p_d     = rx_s_q;
            state_d = S_STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`endif

      S_STOP: begin
        if (tick) begin
          if (s_q == TICK_STOP) begin
            s_d     = '0;
            state_d = S_FINISH;
            done_d  = 1'b1;
            dout_d  = b_q;
            ferr_d  = ~rx_s_q;
            armed_d = rx_s_q;
`ifdef UART_RX_PARITY_EN
            perr_d  = ((^b_q) ^ p_q) != PARITY_ODD;
`endif
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      S_FINISH: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.rx_done_tick = done_q;
  assign bus.dout         = dout_q;
  assign bus.framing_err  = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err   = perr_q;
`else
  assign bus.parity_err   = PERR_TIE;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: directed table, hand-written corner sequences and random frames
// on two configurations (8 data/1 stop/even, 7 data/2 stop/odd).
module tb_uart_rx_param;

  localparam int unsigned OVS   = 16;
  localparam int unsigned DBIT0 = 8;
  localparam int unsigned SB0   = 16;
  localparam bit          ODD0  = 1'b0;
  localparam int unsigned DBIT1 = 7;
  localparam int unsigned SB1   = 32;
  localparam bit          ODD1  = 1'b1;
`ifdef UART_RX_PARITY_EN
  localparam bit          PAR_EN = 1'b1;
`else
  localparam bit          PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_rx_param_if #(.DBIT(DBIT0)) if0 ();
  uart_rx_param_if #(.DBIT(DBIT1)) if1 ();

  uart_rx_param #(.DBIT(DBIT0), .OVS(OVS), .SB_TICK(SB0), .PARITY_ODD(ODD0)) dut0 (
    .clk(clk), .reset(reset), .bus(if0)
  );
  uart_rx_param #(.DBIT(DBIT1), .OVS(OVS), .SB_TICK(SB1), .PARITY_ODD(ODD1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Oversampling tick: one pulse every tick_div clocks, shared by both receivers.
  int unsigned tick_div = 1;
  int unsigned tick_cnt = 0;
  initial begin
    if0.s_tick = 1'b0;
    if1.s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_cnt + 1 >= tick_div) begin
        tick_cnt = 0;
        if0.s_tick = 1'b1;
        if1.s_tick = 1'b1;
      end else begin
        tick_cnt++;
        if0.s_tick = 1'b0;
        if1.s_tick = 1'b0;
      end
    end
  end

  typedef struct {
    logic [8:0]  dout;
    logic        ferr;
    logic        perr;
    int unsigned cyc;
  } done_t;

  done_t       mq0[$];
  done_t       mq1[$];
  logic        prev0 = 1'b0;
  logic        prev1 = 1'b0;
  int unsigned width_bad = 0;

  always @(negedge clk) begin
    if (if0.rx_done_tick === 1'b1) begin
      mq0.push_back('{9'(if0.dout), if0.framing_err, if0.parity_err, cyc});
      if (prev0) width_bad++;
    end
    if (if1.rx_done_tick === 1'b1) begin
      mq1.push_back('{9'(if1.dout), if1.framing_err, if1.parity_err, cyc});
      if (prev1) width_bad++;
    end
    prev0 = (if0.rx_done_tick === 1'b1);
    prev1 = (if1.rx_done_tick === 1'b1);
  end

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int guard;
      guard = 0;
      do begin
        @(posedge clk);
        guard++;
      end while (if0.s_tick !== 1'b1 && guard < 64);
      if (guard >= 64) begin
        $display("FAIL tick_wait: no s_tick within 64 clocks");
        $fatal(1, "tick source stalled");
      end
    end
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) if0.rx = v;
    else            if1.rx = v;
  endtask

  task automatic drive_bit(input int which, input logic v, input int n);
    #2;
    set_line(which, v);
    wait_ticks(n);
  endtask

  int unsigned fall_cyc;

  task automatic send_frame(input int which, input logic [8:0] data, input logic par,
                            input logic stop, input int gap);
    int nb;
    int sb;
    nb = (which == 0) ? int'(DBIT0) : int'(DBIT1);
    sb = (which == 0) ? int'(SB0) : int'(SB1);
    @(posedge clk);
    #2;
    set_line(which, 1'b0);
    fall_cyc = cyc;
    wait_ticks(OVS);
    for (int i = 0; i < nb; i++) drive_bit(which, data[i], OVS);
    if (PAR_EN) drive_bit(which, par, OVS);
    drive_bit(which, stop, sb);
    if (!stop) drive_bit(which, 1'b1, 2 * OVS);
    if (gap > 0) drive_bit(which, 1'b1, gap);
  endtask

  // Done must be high in the cycle after the edge that consumes the last stop tick (tick_div = 1).
  function automatic int unsigned done_cyc(input int which, input int unsigned fall);
    int unsigned nb;
    int unsigned sb;
    nb = (which == 0) ? DBIT0 : DBIT1;
    sb = (which == 0) ? SB0 : SB1;
    return fall + 3 + OVS / 2 + nb * OVS + (PAR_EN ? OVS : 0) + sb;
  endfunction

  task automatic expect_frame(input int which, input string name, input logic [8:0] edout,
                              input logic eferr, input logic eperr,
                              input bit chk_cyc, input int unsigned ecyc);
    done_t d;
    int    n;
    n = (which == 0) ? mq0.size() : mq1.size();
    check({name, "_count"}, 32'(n), 32'd1);
    if (n == 0) return;
    if (which == 0) begin
      d = mq0.pop_front();
      mq0.delete();
    end else begin
      d = mq1.pop_front();
      mq1.delete();
    end
    check({name, "_dout"}, 32'(d.dout), 32'(edout));
    check({name, "_ferr"}, 32'(d.ferr), 32'(eferr));
    check({name, "_perr"}, 32'(d.perr), 32'(eperr));
    if (chk_cyc) check({name, "_done_cycle"}, d.cyc, ecyc);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_done0"}, 32'(if0.rx_done_tick), 32'd0);
    check({tag, "_dout0"}, 32'(if0.dout), 32'd0);
    check({tag, "_ferr0"}, 32'(if0.framing_err), 32'd0);
    check({tag, "_perr0"}, 32'(if0.parity_err), 32'd0);
    check({tag, "_dout1"}, 32'(if1.dout), 32'd0);
    check({tag, "_ferr1"}, 32'(if1.framing_err), 32'd0);
  endtask

  typedef struct {
    logic [8:0] data;
    logic       par;
    logic       stop;
    logic [8:0] exp_dout;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int unsigned t_exp;
    reset  = 1'b1;
    if0.rx = 1'b1;
    if1.rx = 1'b1;

    // exp_perr is the expectation with the parity stage compiled in (even parity on receiver 0).
    tbl[0] = '{9'h0A5, 1'b0, 1'b1, 9'h0A5, 1'b0, 1'b0};
    tbl[1] = '{9'h03C, 1'b0, 1'b1, 9'h03C, 1'b0, 1'b0};
    tbl[2] = '{9'h081, 1'b0, 1'b0, 9'h081, 1'b1, 1'b0};
    tbl[3] = '{9'h042, 1'b0, 1'b1, 9'h042, 1'b0, 1'b0};
    tbl[4] = '{9'h007, 1'b1, 1'b1, 9'h007, 1'b0, 1'b0};
    tbl[5] = '{9'h007, 1'b0, 1'b1, 9'h007, 1'b0, 1'b1};
    tbl[6] = '{9'h000, 1'b0, 1'b1, 9'h000, 1'b0, 1'b0};
    tbl[7] = '{9'h0FF, 1'b1, 1'b0, 9'h0FF, 1'b1, 1'b1};

    repeat (4) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    @(posedge clk);
    #2;
    reset = 1'b0;
    wait_ticks(10);

    // 0xA5 with exact done timing.
    tick_div = 1;
    wait_ticks(2);
    send_frame(0, 9'h0A5, 1'b0, 1'b1, 4);
    t_exp = done_cyc(0, fall_cyc);
    expect_frame(0, "a5_timed", 9'h0A5, 1'b0, 1'b0, 1'b1, t_exp);

    for (int i = 0; i < 8; i++) begin
      tick_div = 1 + (i % 3);
      send_frame(0, tbl[i].data, tbl[i].par, tbl[i].stop, 8);
      expect_frame(0, $sformatf("tbl%0d", i), tbl[i].exp_dout, tbl[i].exp_ferr,
                   PAR_EN & tbl[i].exp_perr, 1'b0, 0);
    end

    // Three-tick low glitch must be rejected, leaving dout alone.
    tick_div = 1;
    wait_ticks(2);
    drive_bit(0, 1'b0, 3);
    drive_bit(0, 1'b1, 40);
    check("glitch_no_done", 32'(mq0.size()), 32'd0);
    check("glitch_dout_hold", 32'(if0.dout), 32'h0FF);
    send_frame(0, 9'h03C, 1'b0, 1'b1, 4);
    t_exp = done_cyc(0, fall_cyc);
    expect_frame(0, "after_glitch", 9'h03C, 1'b0, 1'b0, 1'b1, t_exp);

    // Break: line low for 12 bit periods yields one all-zero frame with a framing error.
    wait_ticks(2);
    drive_bit(0, 1'b0, OVS * 12);
    drive_bit(0, 1'b1, OVS * 3);
    expect_frame(0, "break", 9'h000, 1'b1, 1'b0, 1'b0, 0);
    send_frame(0, 9'h03C, 1'b0, 1'b1, 4);
    expect_frame(0, "after_break", 9'h03C, 1'b0, 1'b0, 1'b0, 0);

    // Seven data bits, two stop bits, odd parity.
    send_frame(1, 9'h055, 1'b1, 1'b1, 4);
    t_exp = done_cyc(1, fall_cyc);
    expect_frame(1, "d7_55", 9'h055, 1'b0, 1'b0, 1'b1, t_exp);
    send_frame(1, 9'h007, 1'b1, 1'b1, 4);
    expect_frame(1, "odd_07_p1", 9'h007, 1'b0, PAR_EN, 1'b0, 0);
    send_frame(1, 9'h007, 1'b0, 1'b1, 4);
    expect_frame(1, "odd_07_p0", 9'h007, 1'b0, 1'b0, 1'b0, 0);

    // Reset in the middle of data bit 4 of 0xFF: aborts with nothing reported.
    wait_ticks(2);
    drive_bit(0, 1'b0, OVS);
    drive_bit(0, 1'b1, 4 * OVS + OVS / 2);
    #2;
    reset = 1'b1;
    #1;
    check_cleared("midreset");
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    wait_ticks(OVS * 12);
    check("midreset_no_done", 32'(mq0.size()), 32'd0);
    check("midreset_dout_hold", 32'(if0.dout), 32'd0);
    send_frame(0, 9'h03C, 1'b0, 1'b1, 4);
    expect_frame(0, "after_reset", 9'h03C, 1'b0, 1'b0, 1'b0, 0);

    // Random frames against a parity/framing model built from frame contents.
    for (int i = 0; i < 30; i++) begin
      int         which;
      int         nb;
      bit         odd;
      logic [8:0] d;
      logic       flip;
      logic       stop;
      logic       par;
      logic       eperr;
      int         ones;
      which    = int'($urandom_range(0, 1));
      nb       = (which == 0) ? int'(DBIT0) : int'(DBIT1);
      odd      = (which == 0) ? ODD0 : ODD1;
      tick_div = $urandom_range(1, 3);
      d        = 9'($urandom) & 9'((1 << nb) - 1);
      flip     = ($urandom_range(0, 5) == 0);
      stop     = ($urandom_range(0, 5) != 0);
      ones     = $countones(d);
      par      = 1'((ones + int'(odd)) % 2) ^ flip;
      eperr    = PAR_EN && (((ones + int'(par)) % 2) != int'(odd));
      send_frame(which, d, par, stop, int'($urandom_range(0, 3)) * 4);
      expect_frame(which, $sformatf("rnd%0d", i), d, ~stop, eperr, 1'b0, 0);
    end

    wait_ticks(OVS * 4);
    check("done_pulse_width", width_bad, 32'd0);
    check("stray_frames", 32'(mq0.size() + mq1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver: the next-generation receive path for the TP2-UART datapath. It is driven by the shared baud-rate tick generator (`s_tick`) and feeds the receive FIFO/interface stage. It adds several things to the fixed 8N1 receiver:
- configurable data width and oversampling;
- input synchronisation;
- false-start rejection;
- framing-error reporting;
- optional parity checking.

## Interface
- `DBIT`, 8 — data bits per frame, legal range 5..9, sent LSB first.
- `OVS`, 16 — `s_tick` pulses per bit period; even, ≥ 4.
- `SB_TICK`, 16 — `s_tick` pulses in the stop period; `OVS` means 1 stop bit, `2*OVS` means 2 stop bits.
- `PARITY_ODD`, 0 — 0 = even parity, 1 = odd parity. Only used when parity is compiled in.
- `clk` in 1 — single system clock; all logic runs on its rising edge.
- `reset` in 1 — asynchronous, active-high.
- `rx` in 1 — serial line, idle high, asynchronous to `clk`.
- `s_tick` in 1 — one-`clk`-wide oversampling enable, `OVS` pulses per bit.
- `rx_done_tick` out 1 — one-cycle pulse when a frame completes.
- `dout` out `DBIT` — last received data word.
- `framing_err` out 1 — stop bit of the last frame was sampled low.
- `parity_err` out 1 — parity mismatch on the last frame.

## Operation
- `rx` passes through a 2-flop synchroniser (reset value 1). All sampling uses the synchronised `rx_s`.
- Counters:
  - `s_reg` has width `$clog2(max(OVS,SB_TICK))` and counts only on `s_tick`.
  - `n_reg` has width `$clog2(DBIT)`.
  - Shift register `b_reg` is `DBIT` wide.
- IDLE:
  - `rx_s` == 0 → START, `s_reg` = 0.
- START:
  - On each tick, `s_reg`++.
  - At the tick where `s_reg` == `OVS/2-1` (mid start bit): if `rx_s` == 1 it is a false start → IDLE with no outputs touched; else → DATA with `s_reg` = 0, `n_reg` = 0.
- DATA:
  - At the tick where `s_reg` == `OVS-1`: `b_reg` = {`rx_s`, `b_reg[DBIT-1:1]`} and `s_reg` = 0.
  - If `n_reg` == `DBIT-1`, go to PARITY (when compiled in) or STOP; else `n_reg`++.
- PARITY:
  - At the tick where `s_reg` == `OVS-1`, latch the parity bit `p` → STOP, `s_reg` = 0.
- STOP:
  - At the tick where `s_reg` == `SB_TICK-1`, sample `rx_s` → FINISH.
- FINISH (one clk, no tick needed):
  - `rx_done_tick` = 1, `dout` = `b_reg`, `framing_err` = ~stop sample, `parity_err` = computed flag → IDLE.
- Without `s_tick`, state and counters hold indefinitely.
- `dout`, `framing_err` and `parity_err` are registered. They change only in FINISH and hold until the next completed frame. A frame with an error still updates `dout` and pulses `rx_done_tick`.
- Break (line held low): this produces a frame with `dout` = 0 and `framing_err` = 1. The receiver then stays in IDLE→START cycling only once the line returns high. IDLE re-arms only after `rx_s` is seen high in STOP or IDLE.

## Timing
- Reset values: `rx_done_tick` 0, `dout` 0, `framing_err` 0, `parity_err` 0, state IDLE, all counters 0.
- Reset asserted mid-frame aborts immediately and returns to the reset values. No partial frame is ever reported.
- Input latency: 2 clk from the `rx` edge to `rx_s`.
- `rx_done_tick` is high for exactly 1 clk: the cycle after the clk edge that consumed the final stop `s_tick`. `dout` and the error flags are valid in that same cycle.
- Back-to-back frames: IDLE is re-entered the cycle after FINISH, and a start bit already low at that point is accepted on the next clk.
- `s_tick` on consecutive clk cycles is legal; each tick advances `s_reg` by exactly 1.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state exists.
  - `parity_err` = (^`b_reg` ^ `p`) != `PARITY_ODD`.
- `UART_RX_PARITY_EN` undefined:
  - No PARITY state; DATA goes directly to STOP.
  - `parity_err` is tied to constant 0. The port stays present.
  - `PARITY_ODD` is ignored.

## Test plan
- Default params, send 0xA5 8N1 with 16 ticks/bit → exactly one `rx_done_tick`, `dout` = 0xA5, `framing_err` = 0. Also check the done timing is 1 clk after the last stop tick.
- Low glitch of 3 ticks on an idle line → no `rx_done_tick`, state back to IDLE, `dout` unchanged. A subsequent 0x3C is received correctly.
- Send 0x81 with the stop bit forced low → `rx_done_tick` pulses, `dout` = 0x81, `framing_err` = 1. The next clean 0x42 frame clears `framing_err` to 0.
- `UART_RX_PARITY_EN`, `PARITY_ODD` = 0:
  - 0x07 with parity bit 1 → `parity_err` = 0.
  - Same data with parity bit 0 → `parity_err` = 1.
  - Repeat with `PARITY_ODD` = 1 and expect the inverted result.
- `DBIT` = 7, `SB_TICK` = 32, send 0x55 with 2 stop bits → `dout` = 7'h55, single done pulse 32 ticks after the last data sample.
- Assert `reset` during data bit 4 of 0xFF → all outputs 0, no done pulse. After release, 0x3C is received correctly.
